can_clic_regs: RTL and testbench

- State/handshake side of the CLIC. Holds the per-interrupt entry bank (pending, enable, priority, trigger mode) and drives it to the combinational `can_clic` arbiter.
- Takes the arbiter's `is_interrupt`/`index` result back in, then runs the request/acknowledge/complete handshake with the core.
- Captures source edges and levels, clears pending on acknowledge, and blocks new requests until completion. No nesting.

---
 rtl/can_clic_pkg.sv | 33 +++
 rtl/can_clic_gateway.sv | 51 +++++
 rtl/can_clic_regs.sv | 124 ++++++++++++
 tb/tb_can_clic_regs.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_clic_pkg.sv
// Shared types and defaults for the CLIC register/handshake block.
package can_clic_pkg;

  localparam int CLIC_N_IRQ  = 4;
  localparam int CLIC_PRIO_W = 1;
  localparam int CLIC_IDX_W  = $clog2(CLIC_N_IRQ);

  // Trigger mode encoding in the config word.
  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  // Entry as seen by the arbiter.
  typedef struct packed {
    logic [CLIC_PRIO_W-1:0] prio;
    logic                   ie;
    logic                   ip;
  } clic_entry_t;

  // Config write word.
  typedef struct packed {
    logic                   trig;
    logic [CLIC_PRIO_W-1:0] prio;
    logic                   ie;
    logic                   ip;
  } clic_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } clic_state_t;

endpackage

// File: rtl/can_clic_gateway.sv
// Per-source gateway: edge/level detect plus the pending flop.
// Set beats clear so an edge landing on the acknowledge cycle is kept.
module can_clic_gateway
  import can_clic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic cfg_wr_i,
  input  logic cfg_trig_i,
  input  logic cfg_ip_i,
  input  logic ack_clr_i,
  output logic ip_o
);

  logic src_q;
  logic trig_q;
  logic ip_q;
  logic ip_d;
  logic hw_set;

  assign hw_set = (trig_q == TRIG_EDGE) ? (src_i & ~src_q) : src_i;

  // Next pending value: a config write replaces the software part, hw_set always ORs in.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    ip_d = (ip_q & ~ack_clr_i) | hw_set;
    if (cfg_wr_i) begin
      ip_d = cfg_ip_i | hw_set;
    end
  end

  // Source history, trigger mode and pending flop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    if (!rst_n) begin
      src_q  <= 1'b0;
      trig_q <= TRIG_LEVEL;
      ip_q   <= 1'b0;
    end else begin
      src_q <= src_i;
      ip_q  <= ip_d;
      if (cfg_wr_i) begin
        trig_q <= cfg_trig_i;
      end
    end
  end

  assign ip_o = ip_q;

endmodule

// File: rtl/can_clic_regs.sv
// CLIC entry bank and core handshake (request / acknowledge / complete).
// The arbiter result (is_interrupt, index) comes from an external can_clic.
module can_clic_regs
  import can_clic_pkg::*;
#(
  parameter int N_IRQ  = CLIC_N_IRQ,
  parameter int PRIO_W = CLIC_PRIO_W,
  parameter int IDX_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_IRQ-1:0]               irq_src,
  input  logic                           cfg_we,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic [PRIO_W+2:0]              cfg_wdata,
  output logic [N_IRQ-1:0][PRIO_W+1:0]   entries,
  input  logic                           is_interrupt,
  input  logic [IDX_W-1:0]               index,
  output logic                           irq_req,
  output logic [IDX_W-1:0]               irq_id,
  input  logic                           irq_ack,
  input  logic                           irq_done,
  output logic                           busy
);

  // Config word layout: {trig, prio, ie, ip}.
  localparam int CFG_IP   = 0;
  localparam int CFG_IE   = 1;
  localparam int CFG_TRIG = PRIO_W + 2;

  clic_state_t      state_q;
  logic             irq_req_q;
  logic [IDX_W-1:0] irq_id_q;
  logic             busy_q;
  logic             take_ack;

  // An acknowledge only counts while a request is actually being presented.
  assign take_ack = (state_q == REQ) && is_interrupt && irq_ack;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_entry
    logic              sel;
    logic              ack_clr;
    logic              ie_q;
    logic [PRIO_W-1:0] prio_q;
    logic              ip;

    // Indices >= N_IRQ match no entry, so such writes fall away.
    assign sel     = cfg_we && (cfg_idx == IDX_W'(i));
    assign ack_clr = take_ack && (irq_id_q == IDX_W'(i));

    // Enable and priority of this entry, written by config.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ie_q   <= 1'b0;
        prio_q <= '0;
      end else if (sel) begin
        ie_q   <= cfg_wdata[CFG_IE];
        prio_q <= cfg_wdata[CFG_TRIG-1:CFG_IE+1];
      end
    end

    can_clic_gateway u_gateway (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_i      (irq_src[i]),
      .cfg_wr_i   (sel),
      .cfg_trig_i (cfg_wdata[CFG_TRIG]),
      .cfg_ip_i   (cfg_wdata[CFG_IP]),
      .ack_clr_i  (ack_clr),
      .ip_o       (ip)
    );

    assign entries[i] = {prio_q, ie_q, ip};
  end

  // Handshake FSM with registered request, id and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_interrupt) begin
            state_q   <= REQ;
            irq_req_q <= 1'b1;
            irq_id_q  <= index;
          end
        end
        REQ: begin
          if (!is_interrupt) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
          end else if (irq_ack) begin
            state_q   <= BUSY;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            // Track the arbiter so a higher-priority arrival replaces the id before ack.
            irq_id_q <= index;
          end
        end
        BUSY: begin
          if (irq_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          irq_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_can_clic_regs.sv
// Directed bench for can_clic_regs with a behavioural arbiter and an id scoreboard.
module tb_can_clic_regs;
  import can_clic_pkg::*;

  localparam int N  = CLIC_N_IRQ;
  localparam int PW = CLIC_PRIO_W;
  localparam int IW = CLIC_IDX_W;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           irq_src;
  logic                   cfg_we;
  logic [IW-1:0]          cfg_idx;
  logic [PW+2:0]          cfg_wdata;
  logic [N-1:0][PW+1:0]   entries;
  logic                   is_interrupt;
  logic [IW-1:0]          index;
  logic                   irq_req;
  logic [IW-1:0]          irq_id;
  logic                   irq_ack;
  logic                   irq_done;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW-1:0] exp_q[$];

  can_clic_regs #(.N_IRQ(N), .PRIO_W(PW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_src      (irq_src),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_wdata    (cfg_wdata),
    .entries      (entries),
    .is_interrupt (is_interrupt),
    .index        (index),
    .irq_req      (irq_req),
    .irq_id       (irq_id),
    .irq_ack      (irq_ack),
    .irq_done     (irq_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: highest prio among pending+enabled, lowest index on ties.
  logic [PW-1:0] best;
  always_comb begin
    is_interrupt = 1'b0;
    index        = '0;
    best         = '0;
    for (int i = 0; i < N; i++) begin
      clic_entry_t e;
      e = entries[i];
      if (e.ip && e.ie && (!is_interrupt || e.prio > best)) begin
        is_interrupt = 1'b1;
        index        = IW'(i);
        best         = e.prio;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic ip_bit(input int i);
    clic_entry_t e;
    e = entries[i];
    return e.ip;
  endfunction

  task automatic cfg_write(input int idx, input logic trig, input logic [PW-1:0] prio,
                           input logic ie, input logic ip);
    clic_cfg_t c;
    c = '{trig: trig, prio: prio, ie: ie, ip: ip};
    cfg_we    = 1'b1;
    cfg_idx   = IW'(idx);
    cfg_wdata = c;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Wait (bounded) for a request, compare its id with the scoreboard, then acknowledge.
  task automatic serve(input string tag);
    logic [IW-1:0] exp_id;
    for (int i = 0; i < 20 && irq_req !== 1'b1; i++) tick();
    check({tag, "_req"}, irq_req, 1);
    check({tag, "_sb"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      exp_id = exp_q.pop_front();
      check({tag, "_id"}, irq_id, exp_id);
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_req_drop"}, irq_req, 0);
  endtask

  task automatic finish_handler(input string tag);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check({tag, "_done"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    irq_src   = '0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_wdata = '0;
    irq_ack   = 1'b0;
    irq_done  = 1'b0;

    // Reset state
    #12;
    check("rst_req", irq_req, 0);
    check("rst_id", irq_id, 0);
    check("rst_busy", busy, 0);
    check("rst_entries", entries, 0);
    rst_n = 1'b1;
    tick();

    // Edge capture on entry 1
    cfg_write(1, TRIG_EDGE, 1'b0, 1'b1, 1'b0);
    check("cfg_entry1", entries[1], 3'b010);
    irq_src[1] = 1'b1;
    tick();
    irq_src[1] = 1'b0;
    check("edge_ip1", ip_bit(1), 1);
    check("edge_no_req_yet", irq_req, 0);
    exp_q.push_back(IW'(1));
    tick();
    check("edge_req", irq_req, 1);
    check("edge_id", irq_id, 1);
    serve("edge");
    check("edge_ack_clr", ip_bit(1), 0);
    tick(3);
    check("edge_no_second", irq_req, 0);
    check("edge_still_busy", busy, 1);
    finish_handler("edge");
    tick(3);
    check("edge_quiet", irq_req, 0);

    // Level re-pend on entry 0
    cfg_write(0, TRIG_LEVEL, 1'b0, 1'b1, 1'b0);
    irq_src[0] = 1'b1;
    tick();
    check("lvl_ip0", ip_bit(0), 1);
    exp_q.push_back(IW'(0));
    tick();
    check("lvl_req", irq_req, 1);
    serve("lvl1");
    check("lvl_repend", ip_bit(0), 1);
    exp_q.push_back(IW'(0));
    tick(2);
    check("lvl_busy_blocks", irq_req, 0);
    irq_done = 1'b1;
    tick();
    irq_done   = 1'b0;
    irq_src[0] = 1'b0;
    check("lvl_done", busy, 0);
    check("lvl_idle_gap", irq_req, 0);
    tick();
    check("lvl_second_req", irq_req, 1);
    serve("lvl2");
    check("lvl_cleared", ip_bit(0), 0);
    finish_handler("lvl2");

    // Preemption before ack
    cfg_write(0, TRIG_EDGE, 1'b0, 1'b1, 1'b0);
    cfg_write(1, TRIG_EDGE, 1'b1, 1'b1, 1'b0);
    irq_src[0] = 1'b1;
    tick();
    irq_src[0] = 1'b0;
    irq_src[1] = 1'b1;
    tick();
    irq_src[1] = 1'b0;
    check("pre_req0", irq_req, 1);
    check("pre_id0", irq_id, 0);
    tick();
    check("pre_req1", irq_req, 1);
    check("pre_id1", irq_id, 1);
    exp_q.push_back(IW'(1));
    serve("pre1");
    check("pre_ip1_clr", ip_bit(1), 0);
    check("pre_ip0_kept", ip_bit(0), 1);
    exp_q.push_back(IW'(0));
    finish_handler("pre1");
    serve("pre2");
    check("pre_ip0_clr", ip_bit(0), 0);
    finish_handler("pre2");

    // Disable while requesting
    irq_src[0] = 1'b1;
    tick();
    irq_src[0] = 1'b0;
    tick();
    check("dis_req", irq_req, 1);
    cfg_write(0, TRIG_EDGE, 1'b0, 1'b0, 1'b1);
    check("dis_req_hold", irq_req, 1);
    check("dis_entry0", entries[0], 3'b001);
    tick();
    check("dis_req_drop", irq_req, 0);
    check("dis_ip_kept", ip_bit(0), 1);
    check("dis_not_busy", busy, 0);
    tick(2);
    check("dis_idle", irq_req, 0);

    // Set/clear collision on entry 1
    irq_src[1] = 1'b1;
    tick();
    irq_src[1] = 1'b0;
    tick();
    check("col_req", irq_req, 1);
    check("col_id", irq_id, 1);
    irq_ack    = 1'b1;
    irq_src[1] = 1'b1;
    tick();
    irq_ack    = 1'b0;
    irq_src[1] = 1'b0;
    check("col_ip_kept", ip_bit(1), 1);
    check("col_busy", busy, 1);
    check("col_req_drop", irq_req, 0);
    tick(2);
    check("col_blocked", irq_req, 0);
    exp_q.push_back(IW'(1));
    finish_handler("col1");
    serve("col2");
    check("col_ip_clr", ip_bit(1), 0);
    finish_handler("col2");

    // Async reset while BUSY
    irq_src[1] = 1'b1;
    tick();
    irq_src[1] = 1'b0;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("rstb_busy", busy, 1);
    check("rstb_ip0_pending", ip_bit(0), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstb_busy_clr", busy, 0);
    check("rstb_req_clr", irq_req, 0);
    check("rstb_id_clr", irq_id, 0);
    check("rstb_entries_clr", entries, 0);
    #2;
    rst_n = 1'b1;
    tick();

    // Ignored strobes in IDLE
    irq_done = 1'b1;
    irq_ack  = 1'b1;
    tick(2);
    irq_done = 1'b0;
    irq_ack  = 1'b0;
    check("ign_busy", busy, 0);
    check("ign_req", irq_req, 0);

    // Fresh request on entry 2 after reset
    cfg_write(2, TRIG_EDGE, 1'b1, 1'b1, 1'b0);
    irq_src[2] = 1'b1;
    tick();
    irq_src[2] = 1'b0;
    exp_q.push_back(IW'(2));
    serve("e2");
    finish_handler("e2");

    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
